// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

   localparam int OPCODE_W = 6;

   typedef enum logic [3:0] {
      S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WAIT,
      S_LOAD_WB, S_MEM_WRITE, S_RTYPE_EXEC, S_RTYPE_WB, S_ITYPE_EXEC,
      S_ITYPE_WB, S_BRANCH, S_JUMP, S_HALT
   } ctrl_state_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_IEXT   = 6'h10;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;

   localparam logic [5:0] ALU_OP_RTYPE = 6'h00;
   localparam logic [5:0] ALU_OP_ADD   = 6'h09;

   localparam logic [1:0] SRCB_REG     = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU     = 2'd0;
   localparam logic [1:0] PCSRC_ALU_OUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP    = 2'd2;

   typedef struct packed {
      logic       pc_write_en;
      logic       i_or_d;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [5:0] alu_op;
      logic       jump_and_link;
      logic       is_signed;
      logic       halted;
   } ctrl_t;

   function automatic logic is_itype_op(input logic [5:0] op);
      return (op >= OP_ADDIU && op <= OP_XORI) || op == OP_IEXT;
   endfunction

   function automatic logic is_branch_op(input logic [5:0] op);
      return op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ);
   endfunction

   function automatic logic is_legal_op(input logic [5:0] op);
      return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_J ||
             op == OP_JAL || op == OP_HALT || is_itype_op(op) || is_branch_op(op);
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control vector decode; only BRANCH looks at branch_taken.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  ctrl_state_t state,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        branch_taken,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alu_src_b   = SRCB_FOUR;
            ctrl.alu_op      = ALU_OP_ADD;
            ctrl.pc_source   = PCSRC_ALU;
            ctrl.pc_write_en = 1'b1;
         end
         S_FETCH_WAIT: ctrl.ir_write = 1'b1;
         // Speculatively compute the branch target into ALU_OUT.
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.is_signed = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.is_signed = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         // Address stays on ALU_OUT across the memory latency cycle.
         S_MEM_READ, S_MEM_WAIT: ctrl.i_or_d = 1'b1;
         S_LOAD_WB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_RTYPE_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_OP_RTYPE;
            if (funct == FN_JR) begin
               ctrl.pc_source   = PCSRC_ALU;
               ctrl.pc_write_en = 1'b1;
            end
         end
         S_RTYPE_WB: begin
            ctrl.alu_op    = ALU_OP_RTYPE;
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_ITYPE_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = opcode;
            ctrl.is_signed = !(opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI);
         end
         S_ITYPE_WB: begin
            ctrl.alu_op    = opcode;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REG;
            ctrl.alu_op      = opcode;
            ctrl.pc_source   = PCSRC_ALU_OUT;
            ctrl.pc_write_en = branch_taken;
         end
         S_JUMP: begin
            ctrl.pc_source   = PCSRC_JUMP;
            ctrl.pc_write_en = 1'b1;
            if (opcode == OP_JAL) begin
               ctrl.jump_and_link = 1'b1;
               ctrl.reg_write     = 1'b1;
            end
         end
         S_HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM. Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap
// undefined opcodes into HALT with a sticky illegal_op flag.
module mips_controller
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [OPCODE_W-1:0] funct,
   input  logic                branch_taken,
   output logic                pc_write_en,
   output logic                i_or_d,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [OPCODE_W-1:0] alu_op,
   output logic                jump_and_link,
   output logic                is_signed,
   output logic                halted
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                illegal_op
`endif
);

   ctrl_state_t state, next_state;
   ctrl_t       ctrl, ctrl_out;

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:      next_state = S_FETCH_WAIT;
         S_FETCH_WAIT: next_state = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEM_ADDR;
            else if (opcode == OP_RTYPE)            next_state = S_RTYPE_EXEC;
            else if (is_itype_op(opcode))           next_state = S_ITYPE_EXEC;
            else if (is_branch_op(opcode))          next_state = S_BRANCH;
            else if (opcode == OP_J || opcode == OP_JAL) next_state = S_JUMP;
            else if (opcode == OP_HALT)             next_state = S_HALT;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            else                                    next_state = S_HALT;
`else
            else                                    next_state = S_FETCH;
`endif
         end
         S_MEM_ADDR:   next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:   next_state = S_MEM_WAIT;
         S_MEM_WAIT:   next_state = S_LOAD_WB;
         S_RTYPE_EXEC: next_state = (funct == FN_JR || funct == FN_MULT || funct == FN_MULTU)
                                    ? S_FETCH : S_RTYPE_WB;
         S_ITYPE_EXEC: next_state = S_ITYPE_WB;
         S_HALT:       next_state = S_HALT;
         default:      next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (rst)                                          illegal_q <= 1'b0;
      else if (state == S_DECODE && !is_legal_op(opcode)) illegal_q <= 1'b1;
   end
   assign illegal_op = illegal_q & ~rst;
`endif

   mips_ctrl_decode u_decode (
      .state        (state),
      .opcode       (opcode),
      .funct        (funct),
      .branch_taken (branch_taken),
      .ctrl         (ctrl)
   );

   // Strobes are quiet for the whole reset window, not just after the edge.
   assign ctrl_out      = rst ? '0 : ctrl;
   assign pc_write_en   = ctrl_out.pc_write_en;
   assign i_or_d        = ctrl_out.i_or_d;
   assign mem_write     = ctrl_out.mem_write;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign ir_write      = ctrl_out.ir_write;
   assign reg_dst       = ctrl_out.reg_dst;
   assign reg_write     = ctrl_out.reg_write;
   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign pc_source     = ctrl_out.pc_source;
   assign alu_op        = ctrl_out.alu_op;
   assign jump_and_link = ctrl_out.jump_and_link;
   assign is_signed     = ctrl_out.is_signed;
   assign halted        = ctrl_out.halted;

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller; cycle 1 is the FETCH right after reset release.
module tb_mips_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic       branch_taken = 1'b0;
   logic       pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write;
   logic       alu_src_a, jump_and_link, is_signed, halted;
   logic [1:0] alu_src_b, pc_source;
   logic [5:0] alu_op;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mips_controller #(.OPCODE_W(6)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .branch_taken(branch_taken),
      .pc_write_en(pc_write_en), .i_or_d(i_or_d), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .ir_write(ir_write), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .alu_op(alu_op), .jump_and_link(jump_and_link),
      .is_signed(is_signed), .halted(halted)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      , .illegal_op(illegal_op)
`endif
   );

   wire [20:0] outs = {pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst,
                       reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
                       jump_and_link, is_signed, halted};

   function automatic logic [20:0] mk(input logic pcw, iord, mw, m2r, irw, rdst, rw, asa,
                                      input logic [1:0] asb, pcs, input logic [5:0] aop,
                                      input logic jal, sgn, hlt);
      return {pcw, iord, mw, m2r, irw, rdst, rw, asa, asb, pcs, aop, jal, sgn, hlt};
   endfunction

   logic [20:0] e_fetch, e_fw, e_dec;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      opcode = 6'h23; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 5; c++) step();   // now in MEM_WAIT (cycle 6)
      rst = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         tests++;
         if (outs !== 21'h0) begin
            fails++; $display("FAIL reset_zero[%0d] got %h want %h", c, outs, 21'h0);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      tests++;
      if (outs !== e_fetch) begin
         fails++; $display("FAIL reset_first_fetch got %h want %h", outs, e_fetch);
      end
      step();
      tests++;
      if (outs !== e_fw) begin
         fails++; $display("FAIL reset_then_fetch_wait got %h want %h", outs, e_fw);
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input int n, input string nm,
                             input logic [20:0] c4, input logic [20:0] c5);
      logic [20:0] e [6];
      e = '{e_fetch, e_fw, e_dec, c4, c5, e_fetch};
      opcode = 6'h00; funct = fn;
      do_reset();
      for (int c = 0; c < n; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL %s cyc%0d got %h want %h", nm, c + 1, outs, e[c]);
         end
         step();
      end
   endtask

   task automatic test_mem();
      logic [20:0] e [8];
      logic [20:0] ea;
      ea = mk(0,0,0,0,0,0,0,1, 2'd2, 2'd0, 6'h09, 0,1,0);
      e = '{e_fetch, e_fw, e_dec, ea,
            mk(0,1,0,0,0,0,0,0, 2'd0, 2'd0, 6'h00, 0,0,0),
            mk(0,1,0,0,0,0,0,0, 2'd0, 2'd0, 6'h00, 0,0,0),
            mk(0,0,0,1,0,0,1,0, 2'd0, 2'd0, 6'h00, 0,0,0), e_fetch};
      opcode = 6'h23; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL lw cyc%0d got %h want %h", c + 1, outs, e[c]);
         end
         step();
      end
      e = '{e_fetch, e_fw, e_dec, ea,
            mk(0,1,1,0,0,0,0,0, 2'd0, 2'd0, 6'h00, 0,0,0), e_fetch, e_fw, e_dec};
      opcode = 6'h2B;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL sw cyc%0d got %h want %h", c + 1, outs, e[c]);
         end
         step();
      end
   endtask

   task automatic test_itype(input logic [5:0] op, input logic sgn);
      logic [20:0] e [6];
      e = '{e_fetch, e_fw, e_dec,
            mk(0,0,0,0,0,0,0,1, 2'd2, 2'd0, op, 0,sgn,0),
            mk(0,0,0,0,0,0,1,0, 2'd0, 2'd0, op, 0,0,0), e_fetch};
      opcode = op; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL itype_%h cyc%0d got %h want %h", op, c + 1, outs, e[c]);
         end
         step();
      end
   endtask

   task automatic test_branch(input logic bt);
      logic [20:0] e [5];
      e = '{e_fetch, e_fw, e_dec,
            mk(bt,0,0,0,0,0,0,1, 2'd0, 2'd1, 6'h04, 0,0,0), e_fetch};
      opcode = 6'h04; funct = 6'h00; branch_taken = bt;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL beq_bt%0d cyc%0d got %h want %h", bt, c + 1, outs, e[c]);
         end
         step();
      end
      branch_taken = 1'b0;
   endtask

   task automatic test_jump(input logic [5:0] op, input logic link);
      logic [20:0] e [5];
      e = '{e_fetch, e_fw, e_dec,
            mk(1,0,0,0,0,0,link,0, 2'd0, 2'd2, 6'h00, link,0,0), e_fetch};
      opcode = op; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (outs !== e[c]) begin
            fails++; $display("FAIL jump_%h cyc%0d got %h want %h", op, c + 1, outs, e[c]);
         end
         step();
      end
   endtask

   task automatic test_halt();
      logic [20:0] eh;
      int bad;
      eh = mk(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 6'h00, 0,0,1);
      opcode = 6'h3F; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 3; c++) step();
      opcode = 6'h00;   // decode must not re-dispatch from HALT
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         tests++;
         if (outs !== eh) begin
            fails++; bad++;
            if (bad < 4) $display("FAIL halt cyc%0d got %h want %h", c + 4, outs, eh);
         end
         step();
      end
   endtask

   task automatic test_illegal();
      opcode = 6'h3A; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 3; c++) step();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      for (int c = 0; c < 4; c++) begin
         tests++;
         if ({halted, illegal_op, pc_write_en} !== 3'b110) begin
            fails++;
            $display("FAIL illegal_trap cyc%0d got %b want 110", c + 4, {halted, illegal_op, pc_write_en});
         end
         step();
      end
      do_reset();
      tests++;
      if (illegal_op !== 1'b0) begin
         fails++; $display("FAIL illegal_clear got %b want 0", illegal_op);
      end
`else
      tests++;
      if (outs !== e_fetch) begin
         fails++; $display("FAIL illegal_nop cyc4 got %h want %h", outs, e_fetch);
      end
`endif
   endtask

   task automatic test_back_to_back();
      opcode = 6'h02; funct = 6'h00;
      do_reset();
      for (int c = 0; c < 4; c++) step();
      opcode = 6'h3A;   // NOP follows the jump without reset
      for (int c = 0; c < 3; c++) step();
      opcode = 6'h00; funct = 6'h18;
      for (int c = 0; c < 3; c++) step();
      tests++;
      if (outs !== mk(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 6'h00, 0,0,0)) begin
         fails++; $display("FAIL b2b_mult_exec got %h", outs);
      end
      step();
      tests++;
      if (outs !== e_fetch) begin
         fails++; $display("FAIL b2b_return got %h want %h", outs, e_fetch);
      end
   endtask

   initial begin
      e_fetch = mk(1,0,0,0,0,0,0,0, 2'd1, 2'd0, 6'h09, 0,0,0);
      e_fw    = mk(0,0,0,0,1,0,0,0, 2'd0, 2'd0, 6'h00, 0,0,0);
      e_dec   = mk(0,0,0,0,0,0,0,0, 2'd3, 2'd0, 6'h09, 0,1,0);
      step();
      test_reset();
      test_rtype(6'h21, 6, "rtype_addu",
                 mk(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 6'h00, 0,0,0),
                 mk(0,0,0,0,0,1,1,0, 2'd0, 2'd0, 6'h00, 0,0,0));
      test_rtype(6'h08, 5, "jr",
                 mk(1,0,0,0,0,0,0,1, 2'd0, 2'd0, 6'h00, 0,0,0), e_fetch);
      test_rtype(6'h18, 5, "mult",
                 mk(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 6'h00, 0,0,0), e_fetch);
      test_mem();
      test_itype(6'h0D, 1'b0);
      test_itype(6'h09, 1'b1);
      test_branch(1'b1);
      test_branch(1'b0);
      test_jump(6'h03, 1'b1);
      test_jump(6'h02, 1'b0);
      test_halt();
      test_illegal();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
